// File: rtl/meas_disc_pkg.sv
// meas_disc_pkg: FSM states, default parameters and saturating add for meas_disc.
package meas_disc_pkg;
  typedef enum logic [2:0] {IDLE, ACC, OFS, MUL, DEC} state_e;
  localparam int TSLICE_DEF = 4;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;
  localparam int CW_DEF = 18;
  localparam int FDEPTH_DEF = 4;
  // a and b are sign-extended w-bit values; the 65-bit sum cannot overflow for w <= 63
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [64:0] s, mx, mn;
    s = {a[63], a} + {b[63], b};
    mx = (65'sd1 <<< (w - 1)) - 65'sd1;
    mn = -(65'sd1 <<< (w - 1));
    return s > mx ? mx[63:0] : (s < mn ? mn[63:0] : s[63:0]);
  endfunction
endpackage

// File: rtl/meas_res_fifo.sv
// meas_res_fifo: result FIFO; a push into a full FIFO is dropped unless a pop frees a slot the same cycle.
module meas_res_fifo
  import meas_disc_pkg::*;
#(
  parameter int W = AW_DEF + 1,
  parameter int DEPTH = FDEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q - rd_q) == (PW + 1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem_q[rd_q[PW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[PW-1:0]] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (PW + 1)'(do_push);
      rd_q <= rd_q + (PW + 1)'(do_pop);
    end
endmodule

// File: rtl/meas_disc.sv
// meas_disc: integrates I/Q over a window, removes offset, rotates and thresholds into a result FIFO.
// Define MEAS_DISC_SAT_EN for saturating accumulation/offset subtraction (default wraps).
module meas_disc
  import meas_disc_pkg::*;
#(
  parameter int TSLICE = TSLICE_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW*TSLICE-1:0] xin,
  input  logic [DW*TSLICE-1:0] yin,
  input  logic                 in_valid,
  input  logic                 start,
  input  logic [15:0]          len,
  input  logic [AW-1:0]        xoffset,
  input  logic [AW-1:0]        yoffset,
  input  logic [AW-1:0]        thresh,
  input  logic [CW-1:0]        coscoef,
  input  logic [CW-1:0]        sincoef,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_bit,
  output logic [AW-1:0]        res_proj,
  output logic                 busy,
  output logic                 overrun,
  output logic                 collision,
  input  logic                 clr_err
);
  localparam int PW = AW + CW + 1;
  state_e state_q;
  logic busy_q, overrun_q, collision_q;
  logic [15:0] cnt_q;
  logic signed [AW-1:0] xacc_q, yacc_q, xacc_d, yacc_d, xsum, ysum;
  logic signed [AW-1:0] xoff_q, yoff_q, thresh_q, xs_q, ys_q, xs_d, ys_d, p_q, p_d;
  logic signed [CW-1:0] cos_q, sin_q;
  logic signed [PW-1:0] prod;
  logic push, pop, full, empty;
  logic [AW:0] head;
  always_comb begin
    xsum = '0;
    ysum = '0;
    for (int k = 0; k < TSLICE; k++) begin
      xsum = xsum + AW'($signed(xin[k*DW+:DW]));
      ysum = ysum + AW'($signed(yin[k*DW+:DW]));
    end
  end
`ifdef MEAS_DISC_SAT_EN
  assign xacc_d = AW'(sat_add(64'(xacc_q), 64'(xsum), AW));
  assign yacc_d = AW'(sat_add(64'(yacc_q), 64'(ysum), AW));
  assign xs_d = AW'(sat_add(64'(xacc_q), -64'(xoff_q), AW));
  assign ys_d = AW'(sat_add(64'(yacc_q), -64'(yoff_q), AW));
`else
  assign xacc_d = xacc_q + xsum;
  assign yacc_d = yacc_q + ysum;
  assign xs_d = xacc_q - xoff_q;
  assign ys_d = yacc_q - yoff_q;
`endif
  // coefficients are Q1.(CW-2), so the shift restores the integer scale of xs/ys
  assign prod = PW'(xs_q) * PW'(cos_q) + PW'(ys_q) * PW'(sin_q);
  assign p_d = AW'(prod >>> (CW - 2));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      cnt_q <= '0;
      xacc_q <= '0;
      yacc_q <= '0;
      xoff_q <= '0;
      yoff_q <= '0;
      thresh_q <= '0;
      cos_q <= '0;
      sin_q <= '0;
      xs_q <= '0;
      ys_q <= '0;
      p_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= ACC;
            busy_q <= 1'b1;
            cnt_q <= len == 16'd0 ? 16'd1 : len;
            xacc_q <= '0;
            yacc_q <= '0;
            xoff_q <= xoffset;
            yoff_q <= yoffset;
            thresh_q <= thresh;
            cos_q <= coscoef;
            sin_q <= sincoef;
          end
        ACC:
          if (in_valid) begin
            xacc_q <= xacc_d;
            yacc_q <= yacc_d;
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_q <= OFS;
          end
        OFS: begin
          xs_q <= xs_d;
          ys_q <= ys_d;
          state_q <= MUL;
        end
        MUL: begin
          p_q <= p_d;
          state_q <= DEC;
        end
        DEC: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  assign push = state_q == DEC;
  assign pop = res_valid & res_ready;
  // a fresh error event wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overrun_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      overrun_q <= (overrun_q & ~clr_err) | (push & full & ~pop);
      collision_q <= (collision_q & ~clr_err) | (start & busy_q);
    end
  meas_res_fifo #(.W(AW + 1), .DEPTH(FDEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({p_q >= thresh_q, p_q}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign res_valid = ~empty;
  assign {res_bit, res_proj} = head;
  assign busy = busy_q;
  assign overrun = overrun_q;
  assign collision = collision_q;
endmodule

// File: tb/tb_meas_disc.sv
// tb_meas_disc: scoreboard bench for meas_disc; expected results come from a behavioural model.
module tb_meas_disc;
  typedef struct packed {
    logic b;
    logic [31:0] p;
  } res_t;
  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] xin = '0, yin = '0;
  logic in_valid = 1'b0, start = 1'b0, res_ready = 1'b0, clr_err = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] xoffset = '0, yoffset = '0, thresh = '0;
  logic [17:0] coscoef = '0, sincoef = '0;
  logic res_valid, res_bit, busy, overrun, collision;
  logic [31:0] res_proj;
  res_t exp_q[$];
  res_t e;
  int checks = 0, errors = 0;
  int bl;
  bit ok;

  meas_disc dut (
    .clk(clk), .reset(reset), .xin(xin), .yin(yin), .in_valid(in_valid), .start(start),
    .len(len), .xoffset(xoffset), .yoffset(yoffset), .thresh(thresh), .coscoef(coscoef),
    .sincoef(sincoef), .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit),
    .res_proj(res_proj), .busy(busy), .overrun(overrun), .collision(collision), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic longint fix32(input longint v);
`ifdef MEAS_DISC_SAT_EN
    return v > MAXV ? MAXV : (v < MINV ? MINV : v);
`else
    return longint'(int'(v));
`endif
  endfunction

  function automatic res_t model(input logic [15:0] ln, input logic [63:0] xv, input logic [63:0] yv,
                                 input int xo, input int yo, input int th, input int c, input int s);
    longint sx, sy, xa, ya, xs, ys, p;
    int n, p32;
    res_t r;
    sx = 0; sy = 0; xa = 0; ya = 0;
    for (int k = 0; k < 4; k++) begin
      sx = sx + longint'($signed(xv[k*16+:16]));
      sy = sy + longint'($signed(yv[k*16+:16]));
    end
    n = ln == 16'd0 ? 1 : int'(ln);
    for (int i = 0; i < n; i++) begin
      xa = fix32(xa + sx);
      ya = fix32(ya + sy);
    end
    xs = fix32(xa - longint'(xo));
    ys = fix32(ya - longint'(yo));
    p = (xs * longint'(c) + ys * longint'(s)) >>> 16;
    p32 = int'(p);
    r.b = p32 >= th;
    r.p = p32;
    return r;
  endfunction

  // Starts a window at the current negedge and feeds valid cycles per mask (bit i = cycle i).
  task automatic drive_window(input logic [15:0] ln, input logic [63:0] xv, input logic [63:0] yv,
                              input int xo, input int yo, input int th, input int c, input int s,
                              input logic [31:0] mask, input bit keep, output int busy_low);
    int nv, i, n;
    nv = 0; i = 0; busy_low = 0;
    n = ln == 16'd0 ? 1 : int'(ln);
    start = 1'b1; len = ln; xin = xv; yin = yv; xoffset = xo; yoffset = yo; thresh = th;
    coscoef = c[17:0]; sincoef = s[17:0]; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (nv < n) begin
      in_valid = i < 32 ? mask[i] : 1'b1;
      if (in_valid) nv++;
      i++;
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
    end
    in_valid = 1'b0;
    if (keep) exp_q.push_back(model(ln, xv, yv, xo, yo, th, c, s));
  endtask

  task automatic wait_valid(output bit found);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      if (res_valid === 1'b1) found = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %b want 0", collision); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    res_ready = 1'b0;
    drive_window(16'd3, {4{16'd100}}, 64'd0, 0, 0, 1000, 65536, 0, '1, 1'b1, bl);
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", res_valid); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e) begin errors++; $display("FAIL basic_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    checks++; if (res_proj !== 32'd1200 || res_bit !== 1'b1) begin errors++; $display("FAIL basic_const got %b/%0d want 1/1200", res_bit, $signed(res_proj)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", res_valid); end
  endtask

  task automatic test_gapped();
    drive_window(16'd3, {4{16'd100}}, 64'd0, 0, 0, 1000, 65536, 0, 32'b10101, 1'b1, bl);
    checks++; if (bl != 0) begin errors++; $display("FAIL gapped_busy got %0d low cycles want 0", bl); end
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL gapped_timeout got res_valid=%b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e || res_proj !== 32'd1200) begin errors++; $display("FAIL gapped_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_mixed();
    drive_window(16'd5, {16'd1000, 16'd7, 16'd50, 16'hFED4}, {16'd9, 16'hFFD8, 16'hFFFB, 16'd20},
                 123, -77, 0, 46341, -46341, '1, 1'b1, bl);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mixed_timeout got res_valid=%b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e) begin errors++; $display("FAIL mixed_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    drive_window(16'd0, {4{16'hFFFB}}, 64'd0, 0, 0, -20, 65536, 0, '1, 1'b1, bl);
    repeat (3) @(negedge clk);
    drive_window(16'd0, {4{16'hFFFB}}, 64'd0, 0, 0, -19, 65536, 0, '1, 1'b1, bl);
    repeat (3) @(negedge clk);
    drive_window(16'd2, 64'd0, {4{16'd100}}, 0, 0, 500, 0, 65536, 32'b1101, 1'b1, bl);
    repeat (3) @(negedge clk);
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout_%0d got res_valid=%b want 1", k, res_valid); end
      e = exp_q.pop_front();
      checks++; if ({res_bit, res_proj} !== e) begin errors++; $display("FAIL b2b_result_%0d got %b/%0d want %b/%0d", k, res_bit, $signed(res_proj), e.b, $signed(e.p)); end
      @(negedge clk);
    end
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", res_valid); end
  endtask

  task automatic test_overrun();
    logic [15:0] w;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = 16'(k * 10 + 1);
      drive_window(16'd1, {4{w}}, 64'd0, 0, 0, 0, 65536, 0, '1, k < 4, bl);
      repeat (3) @(negedge clk);
      if (k == 3) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", overrun); end
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL overrun_timeout_%0d got res_valid=%b want 1", k, res_valid); end
      e = exp_q.pop_front();
      checks++; if ({res_bit, res_proj} !== e) begin errors++; $display("FAIL overrun_result_%0d got %b/%0d want %b/%0d", k, res_bit, $signed(res_proj), e.b, $signed(e.p)); end
      @(negedge clk);
    end
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL overrun_dropped got %b want 0", res_valid); end
  endtask

  task automatic test_collision();
    start = 1'b1; len = 16'd4; xin = {4{16'd10}}; yin = '0; xoffset = '0; yoffset = '0;
    thresh = 32'd1000; coscoef = 18'd65536; sincoef = '0;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(model(16'd4, {4{16'd10}}, 64'd0, 0, 0, 1000, 65536, 0));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      start = i == 1;
      len = i == 1 ? 16'd1 : 16'd4;
      xoffset = i == 1 ? 32'd999 : 32'd0;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; len = 16'd4; xoffset = '0;
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL collision_set got %b want 1", collision); end
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL collision_timeout got res_valid=%b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e || res_proj !== 32'd160) begin errors++; $display("FAIL collision_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b1; len = 16'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(16'd3, {4{16'd10}}, 64'd0, 0, 0, 1000, 65536, 0));
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL collision_clr_race got %b want 1", collision); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL collision_clear got %b want 0", collision); end
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL collision2_timeout got res_valid=%b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e) begin errors++; $display("FAIL collision2_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 16'd10; xin = {4{16'd500}}; yin = '0; thresh = '0; coscoef = 18'd65536; sincoef = '0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resetmid_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL resetmid_quiet got valid=%b busy=%b want 0/0", res_valid, busy); end
    drive_window(16'd2, {4{16'd1}}, 64'd0, 0, 0, 0, 65536, 0, '1, 1'b1, bl);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL resetmid_timeout got res_valid=%b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e || res_proj !== 32'd8) begin errors++; $display("FAIL resetmid_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] want;
`ifdef MEAS_DISC_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'hFFFA_0004;
`endif
    drive_window(16'hFFFF, {4{16'h7FFF}}, 64'd0, 0, 0, 0, 65536, 0, '1, 1'b1, bl);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got res_valid=%b want 1", res_valid); end
    e = exp_q.pop_front();
    checks++; if ({res_bit, res_proj} !== e) begin errors++; $display("FAIL sat_result got %b/%0d want %b/%0d", res_bit, $signed(res_proj), e.b, $signed(e.p)); end
    checks++; if (res_proj !== want) begin errors++; $display("FAIL sat_const got %0d want %0d", $signed(res_proj), $signed(want)); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_mixed();
    test_back_to_back();
    test_overrun();
    test_collision();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/meas_disc.md
MEAS_DISC -- requirements
Module: meas_disc

Interface
REQ-001 Parameters SHALL be: TSLICE, default 4, samples per clock; DW, default 16, sample width; AW, default 32, accumulator width; CW, default 18, rotation coefficient width; FDEPTH, default 4, result FIFO depth (power of 2).
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 xin, yin  in  DW*TSLICE  signed demodulated I/Q, slice k at [k*DW+:DW].
REQ-005 in_valid  in  1  xin/yin qualify this cycle.
REQ-006 start  in  1  single-cycle pulse that opens an integration window.
REQ-007 len  in  16  valid cycles to integrate, sampled on accepted start.
REQ-008 xoffset, yoffset, thresh  in  AW  signed, sampled on accepted start.
REQ-009 coscoef, sincoef  in  CW  signed, Q1.(CW-2), sampled on accepted start.
REQ-010 res_valid/res_ready  out/in  1  result FIFO head handshake.
REQ-011 res_bit  out  1; res_proj  out  AW  signed; both form the FIFO head word.
REQ-012 busy  out  1; high in any state other than IDLE.
REQ-013 overrun, collision  out  1  sticky error flags; clr_err  in  1  clears both.

Function
REQ-014 FSM states SHALL be IDLE, ACC, OFS, MUL, DEC; DEC returns to IDLE.
REQ-015 IDLE to ACC on start: accumulators zeroed, counter loaded with max(len,1), parameters latched.
REQ-016 In ACC, each in_valid cycle SHALL add the sign-extended sum of all TSLICE slices to xacc/yacc and decrement the counter; cycles without in_valid SHALL hold.
REQ-017 ACC to OFS SHALL occur on the in_valid cycle where the counter equals 1, after that cycle's addition.
REQ-018 OFS SHALL register xs=xacc-xoffset and ys=yacc-yoffset.
REQ-019 MUL SHALL register p=(xs*coscoef + ys*sincoef) >>> (CW-2), arithmetic shift, truncated to AW.
REQ-020 DEC SHALL push {res_bit=(p>=thresh), res_proj=p} into the FIFO.
REQ-021 res_valid SHALL assert 4 cycles after the final accumulating cycle when the FIFO was empty.
REQ-022 The FIFO SHALL pop on res_valid&res_ready; push and pop in one cycle SHALL both take effect.
REQ-023 A push into a full FIFO SHALL drop the new result and set overrun.
REQ-024 A start while busy SHALL be ignored and SHALL set collision.
REQ-025 If clr_err and a new error event occur in the same cycle, the flag SHALL end set.
REQ-026 res_valid SHALL be 0 when the FIFO is empty; res_bit/res_proj SHALL then be don't-care.

Reset
REQ-027 Asserting reset, including mid-window, SHALL force IDLE and zero the accumulators, FIFO pointers, res_valid, busy, overrun and collision immediately.
REQ-028 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-029 With MEAS_DISC_SAT_EN defined, accumulation and offset subtraction SHALL saturate to the signed AW range.
REQ-030 Without MEAS_DISC_SAT_EN, accumulation and offset subtraction SHALL wrap in two's complement.

Structure
REQ-031 Package meas_disc_pkg SHALL hold the FSM state enum, default parameter constants and the saturating-add function.
REQ-032 The FIFO SHALL be the sub-module meas_res_fifo (width AW+1, depth FDEPTH); all else SHALL reside in meas_disc.

Verification
REQ-033 xin slices all 100, yin all 0, len=3, offsets 0, cos=65536, sin=0, thresh=1000, in_valid constant -> res_proj=1200, res_bit=1, res_valid 4 cycles after third valid.
REQ-034 Same stimulus with in_valid toggling 1,0,1,0,1 -> identical result; busy held throughout.
REQ-035 FDEPTH=4, res_ready=0, five windows -> four results kept, fifth dropped, overrun=1; clr_err -> overrun=0.
REQ-036 start pulsed during ACC -> collision=1 and the running window completes unaffected.
REQ-037 reset pulsed mid-ACC -> busy=0 next cycle, no result pushed, next window accumulates from zero.
REQ-038 xin all 32767, len=65535, AW=32: with MEAS_DISC_SAT_EN -> xacc clamps at 2^31-1; without it -> xacc wraps in two's complement.
